// File: rtl/llc_mem_responder_if.sv
// Bus bundle between the LLC core, llc_mem_responder and the memory command port.
// slave = responder view, master = LLC core / memory side view.
interface llc_mem_responder_if #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 4,
  parameter int LINE_BITS   = 128,
  parameter int WORD_BITS   = 64
);
  logic                             llc_mem_req_valid;
  logic                             llc_mem_req_ready;
  logic                             llc_mem_req_hwrite;
  logic [2:0]                       llc_mem_req_hsize;
  logic                             llc_mem_req_hprot;
  logic [ADDR_BITS-OFFSET_BITS-1:0] llc_mem_req_addr;
  logic [LINE_BITS-1:0]             llc_mem_req_line;

  logic                             llc_mem_rsp_valid;
  logic                             llc_mem_rsp_ready;
  logic [LINE_BITS-1:0]             llc_mem_rsp_line;

  logic                             mem_cmd_valid;
  logic                             mem_cmd_ready;
  logic                             mem_cmd_write;
  logic                             mem_cmd_hprot;
  logic [ADDR_BITS-1:0]             mem_cmd_addr;
  logic [WORD_BITS-1:0]             mem_cmd_wdata;

  logic                             mem_rdata_valid;
  logic [WORD_BITS-1:0]             mem_rdata;

  modport slave (
    input  llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize, llc_mem_req_hprot,
           llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready, mem_cmd_ready,
           mem_rdata_valid, mem_rdata,
    output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line, mem_cmd_valid,
           mem_cmd_write, mem_cmd_hprot, mem_cmd_addr, mem_cmd_wdata
  );

  modport master (
    output llc_mem_req_valid, llc_mem_req_hwrite, llc_mem_req_hsize, llc_mem_req_hprot,
           llc_mem_req_addr, llc_mem_req_line, llc_mem_rsp_ready, mem_cmd_ready,
           mem_rdata_valid, mem_rdata,
    input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp_line, mem_cmd_valid,
           mem_cmd_write, mem_cmd_hprot, mem_cmd_addr, mem_cmd_wdata
  );
endinterface

// File: rtl/llc_mem_responder.sv
// Memory-side responder: splits LLC line requests into word beats and reassembles read lines.
// Optional line counters are enabled with `define LLC_MEM_STATS_EN.
module llc_mem_responder #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 4,
  parameter int LINE_BITS   = 128,
  parameter int WORD_BITS   = 64
) (
  input logic                clk,
  input logic                rst,
  llc_mem_responder_if.slave bus
`ifdef LLC_MEM_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_rd_lines,
  output logic [31:0]        stat_wr_lines
`endif
);

  localparam int LADDR_BITS = ADDR_BITS - OFFSET_BITS;
  localparam int BEATS      = LINE_BITS / WORD_BITS;
  localparam int CNT_W      = $clog2(BEATS) + 1;
  localparam int WORD_BYTES = WORD_BITS / 8;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cmd_cnt;
  logic [CNT_W-1:0]      data_cnt;
  logic [CNT_W-1:0]      cmd_nxt;
  logic [LADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [2:0]            hsize_q;
  logic [LINE_BITS-1:0]  rsp_line;
  logic                  cmd_valid;
  logic                  cmd_write;
  logic                  cmd_hprot;
  logic [ADDR_BITS-1:0]  cmd_addr;
  logic [WORD_BITS-1:0]  cmd_wdata;
  logic                  req_hs;
  logic                  cmd_hs;
  logic                  rsp_hs;
  logic                  rd_last;
  logic                  wr_last;
  logic                  hsize_unused;

  // Offset never carries into the line address: beats stay inside their line.
  function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [LADDR_BITS-1:0] la,
                                                     input logic [CNT_W-1:0] idx);
    logic [OFFSET_BITS-1:0] off;
    off = OFFSET_BITS'(32'(idx) * WORD_BYTES);
    return {la, off};
  endfunction

  function automatic logic [WORD_BITS-1:0] beat_word(input logic [LINE_BITS-1:0] line,
                                                     input logic [CNT_W-1:0] idx);
    logic [WORD_BITS-1:0] w;
    w = '0;
    for (int i = 0; i < BEATS; i++)
      if (idx == CNT_W'(i)) w = line[i*WORD_BITS +: WORD_BITS];
    return w;
  endfunction

  assign bus.llc_mem_req_ready = rst && (state == S_IDLE);
  assign bus.llc_mem_rsp_valid = (state == S_RSP);
  assign bus.llc_mem_rsp_line  = rsp_line;
  assign bus.mem_cmd_valid     = cmd_valid;
  assign bus.mem_cmd_write     = cmd_write;
  assign bus.mem_cmd_hprot     = cmd_hprot;
  assign bus.mem_cmd_addr      = cmd_addr;
  assign bus.mem_cmd_wdata     = cmd_wdata;

  assign req_hs  = bus.llc_mem_req_valid && bus.llc_mem_req_ready;
  assign cmd_hs  = cmd_valid && bus.mem_cmd_ready;
  assign rsp_hs  = bus.llc_mem_rsp_valid && bus.llc_mem_rsp_ready;
  assign cmd_nxt = cmd_cnt + CNT_W'(1);
  assign rd_last = bus.mem_rdata_valid && (data_cnt == LAST_C);
  assign wr_last = cmd_hs && (cmd_cnt == LAST_C);

  // hsize is kept with the request but the beat count is fixed by the line geometry.
  assign hsize_unused = ^hsize_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cmd_cnt   <= '0;
      data_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_hprot <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_line  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_hs) begin
            state     <= bus.llc_mem_req_hwrite ? S_WR : S_RD;
            cmd_cnt   <= '0;
            data_cnt  <= '0;
            cmd_valid <= 1'b1;
            cmd_write <= bus.llc_mem_req_hwrite;
            cmd_hprot <= bus.llc_mem_req_hprot;
            cmd_addr  <= beat_addr(bus.llc_mem_req_addr, '0);
            cmd_wdata <= bus.llc_mem_req_hwrite ? beat_word(bus.llc_mem_req_line, '0) : '0;
          end
        end
        S_RD: begin
          if (cmd_hs) begin
            cmd_cnt <= cmd_nxt;
            if (cmd_nxt == BEATS_C) cmd_valid <= 1'b0;
            else                    cmd_addr  <= beat_addr(addr_q, cmd_nxt);
          end
          // Returned data is independent of the command side and may land in the same cycle.
          if (bus.mem_rdata_valid) begin
            for (int i = 0; i < BEATS; i++)
              if (data_cnt == CNT_W'(i)) rsp_line[i*WORD_BITS +: WORD_BITS] <= bus.mem_rdata;
            data_cnt <= data_cnt + CNT_W'(1);
          end
          if (rd_last) begin
            state     <= S_RSP;
            cmd_valid <= 1'b0;
          end
        end
        S_RSP: begin
          if (rsp_hs) state <= S_IDLE;
        end
        S_WR: begin
          if (cmd_hs) begin
            cmd_cnt <= cmd_nxt;
            if (wr_last) begin
              state     <= S_IDLE;
              cmd_valid <= 1'b0;
              cmd_write <= 1'b0;
            end else begin
              cmd_addr  <= beat_addr(addr_q, cmd_nxt);
              cmd_wdata <= beat_word(line_q, cmd_nxt);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) begin
      addr_q  <= bus.llc_mem_req_addr;
      line_q  <= bus.llc_mem_req_line;
      hsize_q <= bus.llc_mem_req_hsize;
    end
  end

`ifdef LLC_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst || stat_clr) begin
      stat_rd_lines <= '0;
      stat_wr_lines <= '0;
    end else begin
      if (rsp_hs && (stat_rd_lines != 32'hFFFF_FFFF))
        stat_rd_lines <= stat_rd_lines + 32'd1;
      if (state == S_WR && wr_last && (stat_wr_lines != 32'hFFFF_FFFF))
        stat_wr_lines <= stat_wr_lines + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_mem_responder.sv
// Randomized bench for llc_mem_responder with an in-order behavioural memory and line-level model.
module tb_llc_mem_responder;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 4;
  localparam int LINE_BITS   = 128;
  localparam int WORD_BITS   = 64;
  localparam int BEATS       = LINE_BITS / WORD_BITS;
  localparam int WORD_BYTES  = WORD_BITS / 8;
  localparam int LA_BITS     = ADDR_BITS - OFFSET_BITS;
  localparam int BIG         = 1000000;

  typedef struct {
    logic                 write;
    logic                 hprot;
    logic [ADDR_BITS-1:0] addr;
    logic [WORD_BITS-1:0] wdata;
  } cmd_t;

  typedef struct {
    int unsigned          due;
    logic [ADDR_BITS-1:0] addr;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  llc_mem_responder_if #(.ADDR_BITS(ADDR_BITS), .OFFSET_BITS(OFFSET_BITS),
                         .LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS)) bus ();

`ifdef LLC_MEM_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_rd_lines;
  logic [31:0] stat_wr_lines;
  bit          clr_at_rsp = 1'b0;
`endif

  llc_mem_responder #(.ADDR_BITS(ADDR_BITS), .OFFSET_BITS(OFFSET_BITS),
                      .LINE_BITS(LINE_BITS), .WORD_BITS(WORD_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LLC_MEM_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_rd_lines (stat_rd_lines),
    .stat_wr_lines (stat_wr_lines)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  cmd_t                 cmd_log[$];
  pend_t                pend[$];
  logic [WORD_BITS-1:0] rd_override[$];
  int unsigned          cyc = 0;
  int unsigned          data_cyc = 0;
  int                   stall_left = 0;
  int                   fixed_delay = -1;
  int                   rd_budget = BIG;
  bit                   rand_stall = 1'b0;
  bit                   stray_req = 1'b0;
  bit                   overlap_seen = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WORD_BITS-1:0] mem_word(input logic [ADDR_BITS-1:0] a);
    return {~a, a ^ 32'h5A5A_1234};
  endfunction

  function automatic logic [ADDR_BITS-1:0] exp_beat_addr(input logic [LA_BITS-1:0] la, input int i);
    return (ADDR_BITS'(la) << OFFSET_BITS) + ADDR_BITS'(i * WORD_BYTES);
  endfunction

  // Memory side: accepts commands, returns read beats in order after a delay.
  initial begin
    bit    rdy;
    bit    hs;
    bit    prev_stalled;
    cmd_t  cur;
    cmd_t  snap;
    pend_t p;
    prev_stalled = 1'b0;
    bus.mem_cmd_ready   = 1'b0;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = '{bus.mem_cmd_write, bus.mem_cmd_hprot, bus.mem_cmd_addr, bus.mem_cmd_wdata};
      if (prev_stalled && rst) begin
        check("cmd_hold_valid", 128'(bus.mem_cmd_valid), 128'(1));
        check("cmd_hold_fields", 128'({cur.write, cur.hprot, cur.addr, cur.wdata}),
              128'({snap.write, snap.hprot, snap.addr, snap.wdata}));
      end
      if (stall_left > 0 && bus.mem_cmd_valid) begin
        rdy = 1'b0;
        stall_left--;
      end else if (rand_stall) rdy = ($urandom_range(0, 2) != 0);
      else rdy = 1'b1;
      bus.mem_cmd_ready = rdy;
      prev_stalled = bus.mem_cmd_valid && !rdy;
      snap = cur;
      hs = bus.mem_cmd_valid && rdy;
      if (hs) begin
        cmd_log.push_back(cur);
        if (!cur.write)
          pend.push_back('{cyc + 1 + ((fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3)),
                           cur.addr});
      end
      bus.mem_rdata_valid = 1'b0;
      if (stray_req) begin
        stray_req = 1'b0;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata = {$urandom, $urandom};
      end else if (pend.size() > 0 && rd_budget > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata = (rd_override.size() > 0) ? rd_override.pop_front() : mem_word(p.addr);
        rd_budget--;
        data_cyc = cyc;
        if (hs) overlap_seen = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_req(input bit wr, input logic [LA_BITS-1:0] la,
                          input logic [LINE_BITS-1:0] line, input bit hprot);
    int n;
    bus.llc_mem_req_valid  = 1'b1;
    bus.llc_mem_req_hwrite = wr;
    bus.llc_mem_req_addr   = la;
    bus.llc_mem_req_line   = line;
    bus.llc_mem_req_hprot  = hprot;
    bus.llc_mem_req_hsize  = 3'($urandom_range(0, 7));
    n = 0;
    while (!bus.llc_mem_req_ready && n < 50) begin
      step();
      n++;
    end
    check("req_accept", 128'(bus.llc_mem_req_ready), 128'(1));
    step();
    bus.llc_mem_req_valid = 1'b0;
    check("first_cmd_latency", 128'(bus.mem_cmd_valid), 128'(1));
  endtask

  task automatic check_cmds(input int base, input bit wr, input logic [LA_BITS-1:0] la,
                            input logic [LINE_BITS-1:0] line, input bit hprot);
    check("cmd_count", 128'(cmd_log.size() - base), 128'(BEATS));
    for (int i = 0; i < BEATS && base + i < cmd_log.size(); i++) begin
      check("cmd_addr", 128'(cmd_log[base+i].addr), 128'(exp_beat_addr(la, i)));
      check("cmd_write", 128'(cmd_log[base+i].write), 128'(wr));
      check("cmd_hprot", 128'(cmd_log[base+i].hprot), 128'(hprot));
      if (wr) check("cmd_wdata", 128'(cmd_log[base+i].wdata), 128'(line[i*WORD_BITS +: WORD_BITS]));
    end
  endtask

  task automatic run_read(input logic [LA_BITS-1:0] la, input bit hprot, input int hold,
                          input bit next_pending);
    int                   base;
    int                   n;
    logic [LINE_BITS-1:0] exp;
    base = cmd_log.size();
    for (int i = 0; i < BEATS; i++)
      exp[i*WORD_BITS +: WORD_BITS] = (i < rd_override.size()) ? rd_override[i]
                                                                : mem_word(exp_beat_addr(la, i));
    send_req(1'b0, la, {$urandom, $urandom, $urandom, $urandom}, hprot);
    n = 0;
    while (!bus.llc_mem_rsp_valid && n < 100) begin
      step();
      n++;
    end
    check("rsp_valid", 128'(bus.llc_mem_rsp_valid), 128'(1));
    check("rsp_latency", 128'(cyc), 128'(data_cyc + 1));
    check("rsp_line", bus.llc_mem_rsp_line, exp);
    check("req_ready_in_rsp", 128'(bus.llc_mem_req_ready), 128'(0));
    check_cmds(base, 1'b0, la, '0, hprot);
    if (next_pending) begin
      bus.llc_mem_req_valid  = 1'b1;
      bus.llc_mem_req_hwrite = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      step();
      check("rsp_hold_valid", 128'(bus.llc_mem_rsp_valid), 128'(1));
      check("rsp_hold_line", bus.llc_mem_rsp_line, exp);
      check("req_blocked", 128'(bus.llc_mem_req_ready), 128'(0));
    end
    bus.llc_mem_rsp_ready = 1'b1;
`ifdef LLC_MEM_STATS_EN
    if (clr_at_rsp) stat_clr = 1'b1;
`endif
    step();
    bus.llc_mem_rsp_ready = 1'b0;
`ifdef LLC_MEM_STATS_EN
    stat_clr = 1'b0;
`endif
    check("rsp_dropped", 128'(bus.llc_mem_rsp_valid), 128'(0));
    check("ready_after_rsp", 128'(bus.llc_mem_req_ready), 128'(1));
  endtask

  task automatic run_write(input logic [LA_BITS-1:0] la, input logic [LINE_BITS-1:0] line,
                           input bit hprot, input int stall);
    int base;
    int n;
    bit rsp_seen;
    base = cmd_log.size();
    stall_left = stall;
    rsp_seen = 1'b0;
    send_req(1'b1, la, line, hprot);
    n = 0;
    while (cmd_log.size() < base + BEATS && n < 100) begin
      rsp_seen |= bus.llc_mem_rsp_valid;
      step();
      n++;
    end
    step();
    rsp_seen |= bus.llc_mem_rsp_valid;
    check("ready_after_write", 128'(bus.llc_mem_req_ready), 128'(1));
    check("cmd_idle_after_write", 128'(bus.mem_cmd_valid), 128'(0));
    check("no_rsp_on_write", 128'(rsp_seen), 128'(0));
    check_cmds(base, 1'b1, la, line, hprot);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, 128'(bus.llc_mem_req_ready), 128'(0));
    check({tag, "_rsp_valid"}, 128'(bus.llc_mem_rsp_valid), 128'(0));
    check({tag, "_rsp_line"}, bus.llc_mem_rsp_line, 128'(0));
    check({tag, "_cmd"}, 128'({bus.mem_cmd_valid, bus.mem_cmd_write, bus.mem_cmd_hprot,
                               bus.mem_cmd_addr, bus.mem_cmd_wdata}), 128'(0));
  endtask

  initial begin
    int base;
    bus.llc_mem_req_valid  = 1'b0;
    bus.llc_mem_req_hwrite = 1'b0;
    bus.llc_mem_req_hsize  = 3'd0;
    bus.llc_mem_req_hprot  = 1'b0;
    bus.llc_mem_req_addr   = '0;
    bus.llc_mem_req_line   = '0;
    bus.llc_mem_rsp_ready  = 1'b0;

    rst = 1'b0;
    repeat (3) step();
    check_zero_outputs("reset");
    rst = 1'b1;
    step();
    check("ready_after_reset", 128'(bus.llc_mem_req_ready), 128'(1));

`ifdef LLC_MEM_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) run_read(LA_BITS'($urandom), 1'($urandom), 0, 1'b0);
    for (int i = 0; i < 2; i++)
      run_write(LA_BITS'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 0);
    check("stat_rd_lines", 128'(stat_rd_lines), 128'(3));
    check("stat_wr_lines", 128'(stat_wr_lines), 128'(2));
    clr_at_rsp = 1'b1;
    run_read(LA_BITS'($urandom), 1'b0, 0, 1'b0);
    clr_at_rsp = 1'b0;
    check("stat_rd_clr_wins", 128'(stat_rd_lines), 128'(0));
    check("stat_wr_clr", 128'(stat_wr_lines), 128'(0));
`endif

    // Directed read with fixed returned words.
    base = cmd_log.size();
    rd_override.push_back(64'h1111);
    rd_override.push_back(64'h2222);
    run_read(LA_BITS'('h0000123), 1'b1, 0, 1'b0);
    check("t1_addr0", 128'(cmd_log[base].addr), 128'(32'h1230));
    check("t1_addr1", 128'(cmd_log[base+1].addr), 128'(32'h1238));

    // Directed write with a 3-cycle command stall.
    base = cmd_log.size();
    run_write(LA_BITS'('h0000040), {64'hBBBB, 64'hAAAA}, 1'b0, 3);
    check("t2_beat0", 128'({cmd_log[base].addr, cmd_log[base].wdata}), 128'({32'h400, 64'hAAAA}));
    check("t2_beat1", 128'({cmd_log[base+1].addr, cmd_log[base+1].wdata}), 128'({32'h408, 64'hBBBB}));

    // Beat 0 data in the same cycle as the beat 1 command handshake.
    fixed_delay = 0;
    overlap_seen = 1'b0;
    run_read(LA_BITS'($urandom), 1'b0, 0, 1'b0);
    check("same_cycle_overlap", 128'(overlap_seen), 128'(1));
    fixed_delay = -1;

    // Response held off for 10 cycles with the next request waiting.
    run_read(LA_BITS'($urandom), 1'b1, 10, 1'b1);
    run_write(LA_BITS'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);

    // Reset in the middle of a read with one beat returned.
    rd_budget = 1;
    fixed_delay = 0;
    base = cmd_log.size();
    send_req(1'b0, LA_BITS'('h0000ABC), '0, 1'b1);
    for (int n = 0; (rd_budget != 0 || cmd_log.size() < base + BEATS) && n < 100; n++) step();
    step();
    check("partial_no_rsp", 128'(bus.llc_mem_rsp_valid), 128'(0));
    rst = 1'b0;
    step();
    check_zero_outputs("midreset");
    rst = 1'b1;
    pend.delete();
    rd_budget = BIG;
    fixed_delay = -1;
    stray_req = 1'b1;
    repeat (4) step();
    check("stray_rsp_valid", 128'(bus.llc_mem_rsp_valid), 128'(0));
    check("stray_idle", 128'(bus.llc_mem_req_ready), 128'(1));
    check("stray_rsp_line", bus.llc_mem_rsp_line, 128'(0));
    run_read(LA_BITS'($urandom), 1'b0, 0, 1'b0);

    // Randomized mix with command backpressure.
    rand_stall = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 0)
        run_read(LA_BITS'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
      else
        run_write(LA_BITS'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
